r_return_sched: RTL and testbench

//  Per-master read-data return scheduler for the AXI bridge R channel. Picks one

---
 rtl/axi_pkg.sv | 18 +
 rtl/r_return_sched_pick.sv | 34 +++
 rtl/r_return_sched.sv | 106 ++++++++++
 tb/tb_r_return_sched.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared definitions for the AXI bridge R-channel return scheduling logic.
package axi_pkg;

  localparam logic [2:0] O_IDLE = 3'd0;
  localparam logic [2:0] O_SD   = 3'd1;
  localparam logic [2:0] O_S0   = 3'd2;
  localparam logic [2:0] O_S1   = 3'd3;
  localparam logic [2:0] O_S2   = 3'd4;
  localparam logic [2:0] O_S3   = 3'd5;
  localparam logic [2:0] O_S4   = 3'd6;
  localparam logic [2:0] O_S5   = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } sched_state_e;

endpackage

// File: rtl/r_return_sched_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N     = 7,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     win,
  output logic [IDX_W-1:0] idx
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  always_comb begin
    win      = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= N) cand = cand - N;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found         = 1'b1;
        win[cand_idx] = 1'b1;
        idx           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/r_return_sched.sv
// Per-master R-channel return scheduler: locks the R mux to one slave until
// its RLAST handshake (or watchdog expiry), then rotates priority.
module r_return_sched
  import axi_pkg::*;
#(
  parameter int unsigned N_SLV  = 7,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned TO_CYC = 256,
  parameter int unsigned BEAT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SLV-1:0]  req_i,
  input  logic [N_SLV-1:0]  rlast_i,
  input  logic              rready_m_i,
  output logic [N_SLV-1:0]  gnt_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic [N_SLV-1:0]  rready_s_o,
  output logic              rvalid_m_o,
  output logic              busy_o,
  output logic [BEAT_W-1:0] beats_o,
  output logic              to_err_o
);

  localparam int unsigned PTR_W = $clog2(N_SLV);
  localparam int unsigned WD_W  = $clog2(TO_CYC);

  sched_state_e     state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gidx;
  logic [WD_W-1:0]  wd;

  logic [N_SLV-1:0] pick_win;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] nxt_ptr;
  logic             hs;
  logic             rel_last;
  logic             rel_to;

  rr_pick #(
    .N     (N_SLV),
    .IDX_W (PTR_W)
  ) u_pick (
    .req (req_i),
    .ptr (ptr),
    .win (pick_win),
    .idx (pick_idx)
  );

  always_comb begin
    hs       = (state == LOCK) && req_i[gidx] && rready_m_i;
    rel_last = hs && rlast_i[gidx];
    // Watchdog only advances while the granted slave has nothing to offer.
    rel_to   = (state == LOCK) && !req_i[gidx] && (wd == WD_W'(TO_CYC - 1));
    nxt_ptr  = (gidx == PTR_W'(N_SLV - 1)) ? '0 : gidx + 1'b1;
  end

  assign rready_s_o = gnt_o & req_i & {N_SLV{rready_m_i}};
  assign rvalid_m_o = |(gnt_o & req_i);
  assign busy_o     = (state == LOCK);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      gnt_o    <= '0;
      sel_o    <= SEL_W'(O_IDLE);
      ptr      <= '0;
      gidx     <= '0;
      beats_o  <= '0;
      wd       <= '0;
      to_err_o <= 1'b0;
    end else begin
      to_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_i) begin
            state   <= LOCK;
            gnt_o   <= pick_win;
            sel_o   <= SEL_W'(pick_idx) + SEL_W'(1);
            gidx    <= pick_idx;
            beats_o <= '0;
            wd      <= '0;
          end
        end
        LOCK: begin
          if (rel_last || rel_to) begin
            state    <= IDLE;
            gnt_o    <= '0;
            sel_o    <= SEL_W'(O_IDLE);
            beats_o  <= '0;
            wd       <= '0;
            ptr      <= nxt_ptr;
            to_err_o <= rel_to;
          end else if (hs) begin
            if (beats_o != '1) beats_o <= beats_o + 1'b1;
            wd <= '0;
          end else if (!req_i[gidx]) begin
            wd <= wd + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_r_return_sched.sv
// Directed bench for r_return_sched (watchdog shortened to 4 cycles).
module tb_r_return_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] req_i;
  logic [6:0] rlast_i;
  logic       rready_m_i;
  logic [6:0] gnt_o;
  logic [2:0] sel_o;
  logic [6:0] rready_s_o;
  logic       rvalid_m_o;
  logic       busy_o;
  logic [7:0] beats_o;
  logic       to_err_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  r_return_sched #(
    .N_SLV  (7),
    .SEL_W  (3),
    .TO_CYC (4),
    .BEAT_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .rlast_i    (rlast_i),
    .rready_m_i (rready_m_i),
    .gnt_o      (gnt_o),
    .sel_o      (sel_o),
    .rready_s_o (rready_s_o),
    .rvalid_m_o (rvalid_m_o),
    .busy_o     (busy_o),
    .beats_o    (beats_o),
    .to_err_o   (to_err_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"},  32'(gnt_o),   32'h0);
    chk({tag, "_sel"},  32'(sel_o),   32'h0);
    chk({tag, "_busy"}, 32'(busy_o),  32'h0);
    chk({tag, "_beat"}, 32'(beats_o), 32'h0);
  endtask

  initial begin
    rst = 1'b0; req_i = '0; rlast_i = '0; rready_m_i = 1'b0;
    tick(); tick();
    chk_idle("rst");
    chk("rst_toerr", 32'(to_err_o), 32'h0);
    chk("rst_ptr",   32'(dut.ptr),  32'h0);
    rst = 1'b1;

    // 1: single 4-beat burst from S1 (idx2)
    req_i = 7'b0000100; rready_m_i = 1'b1; #1;
    chk("t1_novalid", 32'(rvalid_m_o), 32'h0);
    chk("t1_nordy",   32'(rready_s_o), 32'h0);
    tick();
    chk("t1_gnt",   32'(gnt_o),   32'h04);
    chk("t1_sel",   32'(sel_o),   32'h3);
    chk("t1_busy",  32'(busy_o),  32'h1);
    chk("t1_b0",    32'(beats_o), 32'h0);
    chk("t1_rvld",  32'(rvalid_m_o), 32'h1);
    tick(); chk("t1_b1", 32'(beats_o), 32'h1);
    tick(); chk("t1_b2", 32'(beats_o), 32'h2);
    tick(); chk("t1_b3", 32'(beats_o), 32'h3);
    rlast_i = 7'b0000100; #1;
    chk("t1_rdy", 32'(rready_s_o), 32'h04);
    tick();
    req_i = '0; rlast_i = '0;
    chk_idle("t1_end");
    chk("t1_ptr", 32'(dut.ptr), 32'h3);

    // 2: round-robin among idx0,2,6 with single-beat bursts, from ptr=0
    rst = 1'b0; tick(); rst = 1'b1;
    chk("t2_ptr0", 32'(dut.ptr), 32'h0);
    req_i = 7'b1000101; rlast_i = 7'b1000101; rready_m_i = 1'b1;
    tick(); chk("t2_g0", 32'(gnt_o), 32'h01); chk("t2_s0", 32'(sel_o), 32'h1);
    tick(); chk("t2_bub0", 32'(gnt_o), 32'h00);
    tick(); chk("t2_g1", 32'(gnt_o), 32'h04); chk("t2_s1", 32'(sel_o), 32'h3);
    tick(); chk("t2_bub1", 32'(gnt_o), 32'h00);
    tick(); chk("t2_g2", 32'(gnt_o), 32'h40); chk("t2_s2", 32'(sel_o), 32'h7);
    tick(); chk("t2_bub2", 32'(gnt_o), 32'h00);
    chk("t2_ptrw", 32'(dut.ptr), 32'h0);
    tick(); chk("t2_g3", 32'(gnt_o), 32'h01);
    req_i = '0; rlast_i = '0;
    tick(); chk("t2_g3_hold", 32'(gnt_o), 32'h01);
    req_i = 7'b0000001; rlast_i = 7'b0000001;
    tick(); req_i = '0; rlast_i = '0;
    chk_idle("t2_end");
    chk("t2_ptr", 32'(dut.ptr), 32'h1);

    // 3: backpressure on S0 (idx1)
    req_i = 7'b0000010; rready_m_i = 1'b1;
    tick(); chk("t3_gnt", 32'(gnt_o), 32'h02); chk("t3_sel", 32'(sel_o), 32'h2);
    rready_m_i = 1'b0; #1;
    chk("t3_nordy", 32'(rready_s_o), 32'h0);
    chk("t3_rvld",  32'(rvalid_m_o), 32'h1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_hold_gnt",  32'(gnt_o),      32'h02);
      chk("t3_hold_beat", 32'(beats_o),    32'h0);
      chk("t3_hold_wd",   32'(dut.wd),     32'h0);
      chk("t3_hold_rdy",  32'(rready_s_o), 32'h0);
    end
    rready_m_i = 1'b1; #1;
    chk("t3_rdy", 32'(rready_s_o), 32'h02);
    tick(); chk("t3_b1", 32'(beats_o), 32'h1);
    rlast_i = 7'b0000010;
    tick(); req_i = '0; rlast_i = '0;
    chk_idle("t3_end");
    chk("t3_ptr", 32'(dut.ptr), 32'h2);

    // 4: watchdog on SD (idx0), ptr=2 wraps to find it
    req_i = 7'b0000001;
    tick(); chk("t4_gnt", 32'(gnt_o), 32'h01); chk("t4_sel", 32'(sel_o), 32'h1);
    req_i = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_busy",  32'(busy_o),   32'h1);
      chk("t4_noerr", 32'(to_err_o), 32'h0);
      chk("t4_nobeat", 32'(beats_o), 32'h0);
    end
    tick();
    chk("t4_err", 32'(to_err_o), 32'h1);
    chk_idle("t4_rel");
    chk("t4_ptr", 32'(dut.ptr), 32'h1);
    tick();
    chk("t4_errpulse", 32'(to_err_o), 32'h0);

    // 5: reset in the middle of an S4 (idx5) burst
    req_i = 7'b0100000; rready_m_i = 1'b1;
    tick(); chk("t5_gnt", 32'(gnt_o), 32'h20); chk("t5_sel", 32'(sel_o), 32'h6);
    tick(); tick(); chk("t5_b2", 32'(beats_o), 32'h2);
    rst = 1'b0;
    tick();
    chk_idle("t5_rst");
    chk("t5_ptr", 32'(dut.ptr), 32'h0);
    chk("t5_rdy", 32'(rready_s_o), 32'h0);
    rst = 1'b1; req_i = 7'b1111111;
    tick(); chk("t5_regnt", 32'(gnt_o), 32'h01); chk("t5_resel", 32'(sel_o), 32'h1);
    rlast_i = 7'b0000001;
    tick(); req_i = '0; rlast_i = '0;
    chk_idle("t5_end");
    chk("t5_ptr1", 32'(dut.ptr), 32'h1);

    // 6: isolation of S3/S5 while S2 (idx3) is locked, then rotation to idx4
    req_i = 7'b1011000; rlast_i = 7'b1010000; rready_m_i = 1'b1;
    tick(); chk("t6_gnt", 32'(gnt_o), 32'h08); chk("t6_sel", 32'(sel_o), 32'h4);
    chk("t6_rdy0", 32'(rready_s_o), 32'h08);
    tick(); chk("t6_b1", 32'(beats_o), 32'h1);
    chk("t6_rdy1", 32'(rready_s_o), 32'h08);
    chk("t6_held", 32'(gnt_o), 32'h08);
    rlast_i = 7'b1011000;
    tick(); chk_idle("t6_rel");
    chk("t6_ptr", 32'(dut.ptr), 32'h4);
    tick(); chk("t6_next", 32'(gnt_o), 32'h10); chk("t6_nsel", 32'(sel_o), 32'h5);
    req_i = '0; rlast_i = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
